// File: rtl/irq_timer_ctrl_pkg.sv
// Shared definitions for the machine timer / interrupt aggregator: register offsets,
// claim ID width, timer width and the byte-strobe merge helper.
package irq_timer_ctrl_pkg;

    localparam int TIMER_W    = 64;
    localparam int CLAIM_ID_W = 5;

    localparam int REG_MTIME_LO    = 'h00;
    localparam int REG_MTIME_HI    = 'h04;
    localparam int REG_MTIMECMP_LO = 'h08;
    localparam int REG_MTIMECMP_HI = 'h0C;
    localparam int REG_PRESCALE    = 'h10;
    localparam int REG_PENDING     = 'h14;
    localparam int REG_ENABLE      = 'h18;
    localparam int REG_CLAIM       = 'h1C;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  wstrb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser plus rising-edge detect; level valid 2 cycles after input,
// rise pulses for exactly one cycle. No flow control.
module irq_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] level_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/irq_timer_ctrl.sv
// Machine timer (mtime/mtimecmp) and N-source pending/enable/claim block driving ti/ei.
// Reads respond exactly one cycle after accept; req_ready is tied high (no back-pressure).
module irq_timer_ctrl
    import irq_timer_ctrl_pkg::*;
#(
    parameter int               N_SRC     = 8,
    parameter logic [N_SRC-1:0] EDGE_MASK = '0,
    parameter int               ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    input  logic [N_SRC-1:0]  irq_src,
    output logic              ti,
    output logic              ei
);

    logic [TIMER_W-1:0] mtime_q, mtime_d;
    logic [TIMER_W-1:0] mtimecmp_q, mtimecmp_d;
    logic [15:0]        prescale_q, prescale_d;
    logic [15:0]        tick_q, tick_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   enable_q, enable_d;
    logic [N_SRC-1:0]   in_service_q, in_service_d;
    logic               ti_q, ei_q, rsp_valid_q;
    logic [31:0]        rsp_rdata_q, rdata;

    logic [N_SRC-1:0]   src_level, src_rise;
    logic [N_SRC-1:0]   claim_cand, claim_onehot, complete_mask, w1c_mask, set_vec, clr_vec;
    logic [CLAIM_ID_W-1:0] claim_id;
    logic [ADDR_W-1:0]  addr_w;
    logic               wr, rd, claim_rd, tick_hit;
    logic               sel_mlo, sel_mhi, sel_clo, sel_chi, sel_pre, sel_pend, sel_en, sel_claim;
    logic               unused_addr_bits;

    irq_sync_edge #(.W(N_SRC)) u_sync (
        .clk     (clk),
        .rst_n   (rst),
        .async_i (irq_src),
        .level_o (src_level),
        .rise_o  (src_rise)
    );

    assign wr       = req_valid & req_we;
    assign rd       = req_valid & ~req_we;
    assign addr_w   = {req_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^req_addr[1:0];

    assign sel_mlo   = (addr_w == ADDR_W'(REG_MTIME_LO));
    assign sel_mhi   = (addr_w == ADDR_W'(REG_MTIME_HI));
    assign sel_clo   = (addr_w == ADDR_W'(REG_MTIMECMP_LO));
    assign sel_chi   = (addr_w == ADDR_W'(REG_MTIMECMP_HI));
    assign sel_pre   = (addr_w == ADDR_W'(REG_PRESCALE));
    assign sel_pend  = (addr_w == ADDR_W'(REG_PENDING));
    assign sel_en    = (addr_w == ADDR_W'(REG_ENABLE));
    assign sel_claim = (addr_w == ADDR_W'(REG_CLAIM));
    assign claim_rd  = rd & sel_claim;

    assign claim_cand = pending_q & enable_q & ~in_service_q;

    // Descending scan so the lowest-index candidate is the one left standing.
    always_comb begin
        claim_id     = '0;
        claim_onehot = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (claim_cand[i]) begin
                claim_id        = CLAIM_ID_W'(i + 1);
                claim_onehot    = '0;
                claim_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        complete_mask = '0;
        w1c_mask      = '0;
        for (int i = 0; i < N_SRC; i++) begin
            complete_mask[i] = wr && sel_claim && (req_wdata == 32'(i + 1));
            w1c_mask[i]      = wr && sel_pend && req_wstrb[i/8] && req_wdata[i];
        end
    end

    always_comb begin
        tick_hit     = (tick_q == prescale_q);
        tick_d       = tick_hit ? '0 : tick_q + 16'd1;
        mtime_d      = tick_hit ? mtime_q + TIMER_W'(1) : mtime_q;
        mtimecmp_d   = mtimecmp_q;
        prescale_d   = prescale_q;
        enable_d     = enable_q;
        in_service_d = in_service_q;

        if (wr) begin
            if (sel_mlo) mtime_d = {mtime_q[63:32], apply_wstrb(mtime_q[31:0], req_wdata, req_wstrb)};
            if (sel_mhi) mtime_d = {apply_wstrb(mtime_q[63:32], req_wdata, req_wstrb), mtime_q[31:0]};
            if (sel_clo) mtimecmp_d[31:0]  = apply_wstrb(mtimecmp_q[31:0], req_wdata, req_wstrb);
            if (sel_chi) mtimecmp_d[63:32] = apply_wstrb(mtimecmp_q[63:32], req_wdata, req_wstrb);
            if (sel_pre) begin
                prescale_d[15:8] = req_wstrb[1] ? req_wdata[15:8] : prescale_q[15:8];
                prescale_d[7:0]  = req_wstrb[0] ? req_wdata[7:0]  : prescale_q[7:0];
                tick_d           = '0;
            end
            if (sel_en) begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (req_wstrb[i/8]) enable_d[i] = req_wdata[i];
                end
            end
            if (sel_claim) in_service_d = in_service_q & ~complete_mask;
        end
        if (claim_rd) in_service_d = in_service_q | claim_onehot;

        // Level sources are gated by next-cycle in_service so a claimed line does not
        // re-pend behind the claim, and re-pends in the same cycle it is completed.
        set_vec   = (EDGE_MASK & src_rise) | (~EDGE_MASK & src_level & ~in_service_d);
        clr_vec   = w1c_mask | (claim_rd ? claim_onehot : '0);
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    always_comb begin
        rdata = '0;
        if (sel_mlo)   rdata = mtime_q[31:0];
        if (sel_mhi)   rdata = mtime_q[63:32];
        if (sel_clo)   rdata = mtimecmp_q[31:0];
        if (sel_chi)   rdata = mtimecmp_q[63:32];
        if (sel_pre)   rdata = {16'h0000, prescale_q};
        if (sel_pend)  rdata = 32'(pending_q);
        if (sel_en)    rdata = 32'(enable_q);
        if (sel_claim) rdata = 32'(claim_id);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            prescale_q   <= '0;
            tick_q       <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            in_service_q <= '0;
            ti_q         <= 1'b0;
            ei_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            prescale_q   <= prescale_d;
            tick_q       <= tick_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            in_service_q <= in_service_d;
            ti_q         <= (mtime_q >= mtimecmp_q);
            ei_q         <= |claim_cand;
            rsp_valid_q  <= rd;
            if (rd) rsp_rdata_q <= rdata;
        end
    end

    assign req_ready = 1'b1;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ti        = ti_q;
    assign ei        = ei_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Bench for irq_timer_ctrl: scenario tasks with randomized stimulus against a rule-level model.
`timescale 1ns/1ps
module tb_irq_timer_ctrl;

    localparam logic [5:0] A_MLO = 6'h00, A_MHI = 6'h04, A_CLO = 6'h08, A_CHI = 6'h0C;
    localparam logic [5:0] A_PRE = 6'h10, A_PEND = 6'h14, A_EN = 6'h18, A_CLAIM = 6'h1C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic [7:0]  irq_src = '0;
    logic        ti, ei;

    int checks = 0;
    int errors = 0;

    irq_timer_ctrl #(.N_SRC(8), .EDGE_MASK(8'h04), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .irq_src(irq_src), .ti(ti), .ei(ei)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output logic v);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0; req_wstrb = '0;
        @(negedge clk);
        d = rsp_rdata; v = rsp_valid;
        req_valid = 1'b0;
    endtask

    // Timer increments landing on edges A+3..A+last after a prescale write at edge A.
    function automatic int incs(input int p, input int last);
        int n = 0;
        for (int m = 3; m <= last; m++) if (m % (p + 1) == 0) n++;
        return n;
    endfunction

    task automatic test_reset();
        logic [31:0] d; logic v;
        if (ti !== 1'b0) begin errors++; $display("FAIL reset_ti: got %b want 0", ti); end
        if (ei !== 1'b0) begin errors++; $display("FAIL reset_ei: got %b want 0", ei); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready: got %b want 1", req_ready); end
        checks += 4;
        bus_read(A_MLO, d, v); checks++;
        if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL reset_mtime_lo: got %h/%b want 0/1", d, v); end
        bus_read(A_CLO, d, v); checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo: got %h want ffffffff", d); end
        bus_read(A_CHI, d, v); checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi: got %h want ffffffff", d); end
        bus_read(A_CLAIM, d, v); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_claim: got %h want 0", d); end
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", rsp_valid); end
        idle(1); checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", rsp_valid); end
    endtask

    task automatic test_ti_compare(input int c);
        logic exp;
        bus_write(A_CHI, 32'h0, 4'hF);
        bus_write(A_CLO, 32'(c), 4'hF);
        bus_write(A_MHI, 32'h0, 4'hF);
        bus_write(A_MLO, 32'h0, 4'hF);
        for (int i = 1; i <= c + 3; i++) begin
            @(negedge clk);
            exp = ((i - 1) >= c);
            checks++;
            if (ti !== exp) begin errors++; $display("FAIL ti_cmp%0d_cyc%0d: got %b want %b", c, i, ti, exp); end
        end
    endtask

    task automatic test_timer_prescale();
        int p, j;
        logic [63:0] w, e;
        logic [31:0] d; logic v;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) begin p = 3; w = '1; j = 3; end
            else if (it == 1) begin p = 3; w = '0; j = 8; end
            else begin p = $urandom_range(0, 6); w = {$urandom, $urandom}; j = $urandom_range(0, 12); end
            bus_write(A_PRE, 32'(p), 4'hF);
            bus_write(A_MLO, w[31:0], 4'hF);
            bus_write(A_MHI, w[63:32], 4'hF);
            idle(j);
            bus_read(A_MLO, d, v);
            e = w + 64'(incs(p, j + 2)); checks++;
            if (d !== e[31:0]) begin errors++; $display("FAIL mtime_lo_p%0d_j%0d: got %h want %h", p, j, d, e[31:0]); end
            bus_read(A_MHI, d, v);
            e = w + 64'(incs(p, j + 3)); checks++;
            if (d !== e[63:32]) begin errors++; $display("FAIL mtime_hi_p%0d_j%0d: got %h want %h", p, j, d, e[63:32]); end
        end
        bus_write(A_PRE, 32'h0, 4'hF);
    endtask

    task automatic test_edge_claim();
        logic [31:0] d; logic v;
        for (int rep = 0; rep < 2; rep++) begin
            irq_src = 8'h04; idle(3); irq_src = 8'h00; idle(3);
            bus_read(A_PEND, d, v); checks++;
            if (d !== 32'h04) begin errors++; $display("FAIL edge_pending%0d: got %h want 04", rep, d); end
            if (rep == 0) begin
                checks++;
                if (ei !== 1'b0) begin errors++; $display("FAIL edge_ei_disabled: got %b want 0", ei); end
                bus_write(A_EN, 32'h04, 4'hF); idle(1); checks++;
                if (ei !== 1'b1) begin errors++; $display("FAIL edge_ei_set: got %b want 1", ei); end
            end
            bus_read(A_CLAIM, d, v); idle(1); checks += 2;
            if (d !== 32'd3) begin errors++; $display("FAIL edge_claim%0d: got %h want 3", rep, d); end
            if (ei !== 1'b0) begin errors++; $display("FAIL edge_ei_clr%0d: got %b want 0", rep, ei); end
            bus_read(A_PEND, d, v); checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL edge_pend_clr%0d: got %h want 0", rep, d); end
            bus_read(A_CLAIM, d, v); checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL edge_claim2_%0d: got %h want 0", rep, d); end
            bus_write(A_CLAIM, 32'h0, 4'hF);
            bus_write(A_CLAIM, 32'd9, 4'hF);
            bus_write(A_CLAIM, 32'd3, 4'hF);
        end
    endtask

    task automatic test_level_claim();
        logic [7:0] lev, en, ids[$];
        logic [31:0] d; logic v;
        for (int it = 0; it < 4; it++) begin
            lev = (it == 0) ? 8'h21 : 8'($urandom) & 8'hFB;
            en  = (it == 0) ? 8'h21 : 8'($urandom);
            ids.delete();
            for (int i = 0; i < 8; i++) if (lev[i] && en[i]) ids.push_back(8'(i + 1));
            irq_src = lev; idle(4);
            bus_write(A_EN, 32'(en), 4'hF);
            bus_read(A_PEND, d, v); checks++;
            if (d !== 32'(lev)) begin errors++; $display("FAIL lvl_pending%0d: got %h want %h", it, d, lev); end
            foreach (ids[k]) begin
                bus_read(A_CLAIM, d, v); checks++;
                if (d !== 32'(ids[k])) begin errors++; $display("FAIL lvl_claim%0d_%0d: got %h want %h", it, k, d, ids[k]); end
            end
            bus_read(A_CLAIM, d, v); idle(1); checks += 2;
            if (d !== 32'h0) begin errors++; $display("FAIL lvl_claim_empty%0d: got %h want 0", it, d); end
            if (ei !== 1'b0) begin errors++; $display("FAIL lvl_ei%0d: got %b want 0", it, ei); end
            bus_read(A_PEND, d, v); checks++;
            if (d !== 32'(lev & ~en)) begin errors++; $display("FAIL lvl_no_repend%0d: got %h want %h", it, d, lev & ~en); end
            if (ids.size() > 0) begin
                bus_write(A_CLAIM, 32'(ids[0]), 4'hF); idle(1);
                bus_read(A_PEND, d, v); checks++;
                if (d !== 32'((lev & ~en) | (8'h01 << (ids[0] - 1)))) begin
                    errors++; $display("FAIL lvl_repend%0d: got %h want %h", it, d, (lev & ~en) | (8'h01 << (ids[0] - 1)));
                end
            end
            foreach (ids[k]) bus_write(A_CLAIM, 32'(ids[k]), 4'hF);
            irq_src = 8'h00; idle(4);
            bus_write(A_PEND, 32'hFF, 4'hF);
            bus_read(A_PEND, d, v); checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL lvl_w1c%0d: got %h want 0", it, d); end
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d; logic v;
        irq_src = 8'h04; idle(2);
        bus_write(A_PEND, 32'h04, 4'hF);
        bus_read(A_PEND, d, v); checks++;
        if (d !== 32'h04) begin errors++; $display("FAIL w1c_race: got %h want 04", d); end
        bus_write(A_PEND, 32'h04, 4'hF);
        bus_read(A_PEND, d, v); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL w1c_plain: got %h want 0", d); end
        irq_src = 8'h00; idle(3);
    endtask

    task automatic test_regs_random();
        logic [31:0] o, w, e, d; logic [3:0] s; logic v;
        for (int it = 0; it < 4; it++) begin
            o = $urandom; w = $urandom; s = 4'($urandom);
            for (int b = 0; b < 4; b++) e[8*b +: 8] = s[b] ? w[8*b +: 8] : o[8*b +: 8];
            bus_write(A_CLO, o, 4'hF); bus_write(A_CLO, w, s);
            bus_read(A_CLO, d, v); checks++;
            if (d !== e) begin errors++; $display("FAIL cmp_lo_strb%0d: got %h want %h", it, d, e); end
            bus_write(A_CHI, o, 4'hF); bus_write(A_CHI, w, s);
            bus_read(A_CHI + 6'd3, d, v); checks++;
            if (d !== e) begin errors++; $display("FAIL cmp_hi_strb%0d: got %h want %h", it, d, e); end
            bus_write(A_PRE, o, 4'hF); bus_write(A_PRE, w, s);
            bus_read(A_PRE, d, v); checks++;
            if (d !== {16'h0, e[15:0]}) begin errors++; $display("FAIL prescale%0d: got %h want %h", it, d, {16'h0, e[15:0]}); end
            bus_write(A_EN, o, 4'hF); bus_write(A_EN, w, s);
            bus_read(A_EN + 6'd2, d, v); checks++;
            if (d !== {24'h0, e[7:0]}) begin errors++; $display("FAIL enable%0d: got %h want %h", it, d, {24'h0, e[7:0]}); end
            bus_write(6'h20 + 6'(4 * (it % 8)), w, 4'hF);
            bus_read(6'h24 + 6'(4 * it), d, v); checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL unmapped%0d: got %h want 0", it, d); end
        end
        bus_write(A_PRE, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] d; logic v;
        bus_write(A_EN, 32'hFF, 4'hF);
        bus_write(A_CLO, 32'h0, 4'hF);
        bus_write(A_CHI, 32'h0, 4'hF);
        req_valid = 1'b1; req_we = 1'b0; req_addr = A_EN;
        #2 rst = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; checks += 4;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0", rsp_rdata); end
        if (ti !== 1'b0) begin errors++; $display("FAIL rstmid_ti: got %b want 0", ti); end
        if (ei !== 1'b0) begin errors++; $display("FAIL rstmid_ei: got %b want 0", ei); end
        @(negedge clk); rst = 1'b1;
        bus_read(A_MLO, d, v); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstmid_mtime_lo: got %h want 0", d); end
        bus_read(A_MHI, d, v); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstmid_mtime_hi: got %h want 0", d); end
        bus_read(A_CLO, d, v); checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_cmp_lo: got %h want ffffffff", d); end
        bus_read(A_CHI, d, v); checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_cmp_hi: got %h want ffffffff", d); end
        bus_read(A_PRE, d, v); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstmid_prescale: got %h want 0", d); end
        bus_read(A_PEND, d, v); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstmid_pending: got %h want 0", d); end
        bus_read(A_EN, d, v); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstmid_enable: got %h want 0", d); end
        bus_read(A_CLAIM, d, v); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstmid_claim: got %h want 0", d); end
    endtask

    initial begin
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        test_reset();
        test_ti_compare(5);
        test_ti_compare($urandom_range(3, 10));
        test_timer_prescale();
        test_edge_claim();
        test_level_claim();
        test_w1c_race();
        test_regs_random();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
